// File: rtl/display_arbiter.sv
// display_arbiter: round-robin sharing of the 4-digit hex display among N_REQ requesters.
// Latency: request sampled at edge E -> ack/dig/owner/busy registered after E; a tenure lasts HOLD_CYCLES.
// Backpressure: waiting requesters hold req_valid until acked; only the owner is acked mid-tenure.
module display_arbiter #(
    parameter int N_REQ       = 3,
    parameter int HOLD_CYCLES = 100_000_000,
    localparam int OW = (N_REQ > 2) ? $clog2(N_REQ) : 1,
    localparam int TW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ-1:0][15:0] req_data,
    output logic [N_REQ-1:0]       req_ack,
    output logic [3:0][3:0]        dig,
    output logic                   busy,
    output logic [OW-1:0]          owner
);

    typedef enum logic {IDLE, SHOW} state_t;

    state_t             state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [OW-1:0]      ptr_q, ptr_d, owner_d, win;
    logic [N_REQ-1:0]   ack_d, eff_valid;
    logic [2*N_REQ-1:0] rot;
    logic [OW:0]        sum;
    logic               found;
    logic [15:0]        dig_d;

    // A requester is blind for the cycle its ack is visible, so a held valid is not double-counted.
    assign eff_valid = req_valid & ~req_ack;
    assign busy      = (state_q == SHOW);

    always_comb begin
        found = 1'b0;
        win   = '0;
        sum   = '0;
        rot   = {eff_valid, eff_valid} >> ptr_q;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                sum   = {1'b0, ptr_q} + (OW+1)'(k);
                if (sum >= (OW+1)'(N_REQ)) begin
                    sum = sum - (OW+1)'(N_REQ);
                end
                win = sum[OW-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        ptr_d   = ptr_q;
        owner_d = owner;
        dig_d   = dig;
        ack_d   = '0;
        if (state_q == SHOW && timer_q != '0) begin
            timer_d = timer_q - 1'b1;
            if (eff_valid[owner]) begin
                dig_d          = req_data[owner];
                ack_d[owner]   = 1'b1;
            end
        end else if (found) begin
            // Both IDLE and expiry land here; expiry wins over an owner refresh in the same cycle.
            state_d    = SHOW;
            timer_d    = TW'(HOLD_CYCLES - 1);
            owner_d    = win;
            ptr_d      = (win == OW'(N_REQ - 1)) ? '0 : win + 1'b1;
            dig_d      = req_data[win];
            ack_d[win] = 1'b1;
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            ptr_q   <= '0;
            owner   <= '0;
            dig     <= '0;
            req_ack <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            ptr_q   <= ptr_d;
            owner   <= owner_d;
            dig     <= dig_d;
            req_ack <= ack_d;
        end
    end

endmodule

// File: tb/tb_display_arbiter.sv
// Bench for display_arbiter with N_REQ=3, HOLD_CYCLES=8: vector table plus hand sequences,
// expected acks queued at stimulus time and matched as they appear.
module tb_display_arbiter;
    localparam int N = 3;
    localparam int H = 8;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic [N-1:0]      req_valid;
    logic [N-1:0][15:0] req_data;
    logic [N-1:0]      req_ack;
    logic [3:0][3:0]   dig;
    logic              busy;
    logic [1:0]        owner;

    display_arbiter #(.N_REQ(N), .HOLD_CYCLES(H)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ack   (req_ack),
        .dig       (dig),
        .busy      (busy),
        .owner     (owner)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; int idx; logic [15:0] data; } exp_t;
    typedef struct { logic [2:0] valid; logic [15:0] d0; logic [15:0] d1; logic [15:0] d2; int w1; int w2; } vec_t;

    exp_t         exp_q[$];
    vec_t         vecs[6];
    int           checks = 0;
    int           failures = 0;
    int           cyc = 0;
    logic [N-1:0] oneshot;
    logic [N-1:0] drop_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input int idx, input logic [15:0] d);
        exp_t e;
        e.cyc = c; e.idx = idx; e.data = d;
        exp_q.push_back(e);
    endtask

    // One clock: one-shot requesters drop valid the cycle after seeing their ack.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        req_valid = req_valid & ~drop_q;
        drop_q    = req_ack & oneshot;
        if (req_ack != '0) begin
            chk("ack_onehot", 32'($onehot(req_ack)), 32'd1);
            if (exp_q.size() == 0) begin
                chk("unexpected_ack", 32'(req_ack), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("ack_cycle", cyc, e.cyc);
                chk("ack_vec", 32'(req_ack), 32'd1 << e.idx);
                chk("ack_dig", 32'(dig), 32'(e.data));
                chk("ack_owner", 32'(owner), e.idx);
            end
        end
    endtask

    task automatic do_reset();
        #2 reset_n = 1'b0;
        req_valid = '0;
        req_data  = '0;
        drop_q    = '0;
        oneshot   = '1;
        exp_q.delete();
        #2 reset_n = 1'b1;
    endtask

    function automatic logic [15:0] pick(input vec_t v, input int w);
        return (w == 0) ? v.d0 : (w == 1) ? v.d1 : v.d2;
    endfunction

    task automatic run_vec(input vec_t v);
        int c0;
        int n;
        logic [15:0] last;
        do_reset();
        req_data  = {v.d2, v.d1, v.d0};
        req_valid = v.valid;
        c0 = cyc;
        n  = (v.w2 < 0) ? 1 : 2;
        push(c0 + 1, v.w1, pick(v, v.w1));
        last = pick(v, v.w1);
        if (n == 2) begin
            push(c0 + 1 + H, v.w2, pick(v, v.w2));
            last = pick(v, v.w2);
        end
        for (int i = 0; i < H * n + 3; i++) begin
            step();
            if (cyc == c0 + 1) chk("vec_busy_first", 32'(busy), 32'd1);
            if (cyc == c0 + H * n) chk("vec_busy_last", 32'(busy), 32'd1);
            if (cyc == c0 + H * n + 1) begin
                chk("vec_busy_fall", 32'(busy), 32'd0);
                chk("vec_dig_kept", 32'(dig), 32'(last));
            end
        end
        chk("vec_missing_acks", exp_q.size(), 0);
    endtask

    initial begin
        int c0;
        int gaps;
        req_valid = '0;
        req_data  = '0;
        oneshot   = '1;
        drop_q    = '0;
        reset_n   = 1'b0;
        #1;
        chk("reset_dig", 32'(dig), 32'd0);
        chk("reset_ack", 32'(req_ack), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_owner", 32'(owner), 32'd0);
        #2 reset_n = 1'b1;

        vecs[0] = '{3'b010, 16'h0000, 16'hBEEF, 16'h0000, 1, -1};
        vecs[1] = '{3'b101, 16'hA0A0, 16'h0000, 16'hC2C2, 0, 2};
        vecs[2] = '{3'b110, 16'h0000, 16'h1B1B, 16'h2C2C, 1, 2};
        vecs[3] = '{3'b100, 16'h0000, 16'h0000, 16'hF00D, 2, -1};
        vecs[4] = '{3'b011, 16'h0123, 16'h4567, 16'h0000, 0, 1};
        vecs[5] = '{3'b001, 16'hCAFE, 16'h0000, 16'h0000, 0, -1};
        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Contention: three one-shot requesters served back to back, no idle gap.
        do_reset();
        req_data  = {16'h3333, 16'h2222, 16'h1111};
        req_valid = 3'b111;
        c0   = cyc;
        gaps = 0;
        push(c0 + 1, 0, 16'h1111);
        push(c0 + 1 + H, 1, 16'h2222);
        push(c0 + 1 + 2 * H, 2, 16'h3333);
        for (int i = 0; i < 3 * H + 3; i++) begin
            step();
            if (cyc >= c0 + 1 && cyc <= c0 + 3 * H && !busy) gaps++;
            if (cyc == c0 + 3 * H + 1) chk("cont_busy_fall", 32'(busy), 32'd0);
        end
        chk("cont_no_idle_gap", gaps, 0);
        chk("cont_missing_acks", exp_q.size(), 0);

        // Owner refresh in the third hold cycle; expiry unchanged.
        do_reset();
        req_data[0] = 16'hABCD;
        req_valid   = 3'b001;
        c0 = cyc;
        push(c0 + 1, 0, 16'hABCD);
        for (int i = 0; i < H + 4; i++) begin
            step();
            if (cyc == c0 + 3) begin
                req_data[0]  = 16'h1234;
                req_valid[0] = 1'b1;
                push(c0 + 4, 0, 16'h1234);
            end
            if (cyc == c0 + H) chk("upd_busy_last", 32'(busy), 32'd1);
            if (cyc == c0 + H + 1) begin
                chk("upd_busy_fall", 32'(busy), 32'd0);
                chk("upd_dig_kept", 32'(dig), 32'h1234);
            end
        end
        chk("upd_missing_acks", exp_q.size(), 0);

        // Fairness: 0 and 2 held valid; each owner also refreshes every other cycle.
        do_reset();
        oneshot   = 3'b010;
        req_data  = {16'hCCCC, 16'h1111, 16'hAAAA};
        req_valid = 3'b101;
        c0 = cyc;
        for (int g = 0; g < 4; g++) begin
            for (int u = 0; u < 4; u++) begin
                push(c0 + 1 + H * g + 2 * u, (g % 2 == 0) ? 0 : 2, (g % 2 == 0) ? 16'hAAAA : 16'hCCCC);
            end
        end
        for (int i = 0; i < 4 * H - 1; i++) step();
        req_valid = '0;
        for (int i = 0; i < 5; i++) step();
        chk("fair_missing_acks", exp_q.size(), 0);
        chk("fair_idle", 32'(busy), 32'd0);

        // Asynchronous reset between edges during a tenure.
        do_reset();
        req_data[1] = 16'h5A5A;
        req_valid   = 3'b010;
        push(cyc + 1, 1, 16'h5A5A);
        for (int i = 0; i < 3; i++) step();
        chk("mid_busy_before", 32'(busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_reset_dig", 32'(dig), 32'd0);
        chk("mid_reset_ack", 32'(req_ack), 32'd0);
        chk("mid_reset_busy", 32'(busy), 32'd0);
        chk("mid_reset_owner", 32'(owner), 32'd0);
        req_valid = '0;
        drop_q    = '0;
        exp_q.delete();
        #2 reset_n = 1'b1;
        req_data[2] = 16'h7E57;
        req_valid   = 3'b100;
        push(cyc + 1, 2, 16'h7E57);
        for (int i = 0; i < H + 3; i++) step();
        chk("mid_missing_acks", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
